axi4_burst_addr_gen: RTL and testbench
======================================

# axi4_burst_addr_gen

Parametrised AXI4 burst address generator. Accepts one AW/AR-style burst descriptor (address, length, size, burst type) and expands it into a per-beat stream of byte addresses, byte-lane strobes and last flags, handling FIXED, INCR and WRAP bursts. It sits behind the AXI4 slave address channels, feeding memory or register back-ends, and uses the shared AXI4 burst size and type encodings.

## Interface
- ADDR_WIDTH, 32, byte address width (≥12)
- DATA_WIDTH, 64, data bus width in bits; power of two, 8..1024
- aclk  in  1  clock; all logic rising-edge
- aresetn  in  1  asynchronous active-low reset
- req_valid  in  1  descriptor valid
- req_ready  out  1  generator can accept a descriptor
- req_addr  in  ADDR_WIDTH  start byte address
- req_len  in  8  beats minus one (AXI4 AxLEN)
- req_size  in  3  burst_size_t, bytes per beat = 2^size
- req_burst  in  2  burst_type_t
- beat_valid  out  1  beat outputs valid
- beat_ready  in  1  consumer accepts beat
- beat_addr  out  ADDR_WIDTH  byte address of beat
- beat_strb  out  DATA_WIDTH/8  active byte lanes
- beat_idx  out  8  beat number, 0..req_len
- beat_last  out  1  final beat of burst
- beat_err  out  1  burst illegal (see Configuration)

## Operation
- FSM IDLE/BURST. IDLE: req_ready=1, beat_valid=0. Handshake req_valid&&req_ready captures descriptor, go BURST. BURST: req_ready=0, beat_valid=1.
- Beat handshake beat_valid&&beat_ready advances beat_idx; if beat_last, return IDLE.
- B = 2^size; aligned = addr & ~(B-1).
- FIXED: every beat beat_addr=req_addr.
- INCR: beat 0 = req_addr; beat n≥1 = aligned + n·B.
- WRAP: W = B·(len+1); lower = addr & ~(W-1); next = current aligned + B; if next == lower+W then next = lower.
- Address arithmetic modulo 2^ADDR_WIDTH.
- beat_strb: lanes (beat_addr mod DB) .. ((aligned_beat mod DB)+B-1), DB=DATA_WIDTH/8; FIXED repeats beat-0 mask.
- beat_last = (beat_idx == captured len).
- req_size > log2(DB) is used unchanged (no clamping) unless checking is enabled.

## Timing
- Reset values: req_ready=1, beat_valid=0, beat_addr=0, beat_strb=0, beat_idx=0, beat_last=0, beat_err=0; state IDLE.
- Latency: beat 0 valid the cycle after request handshake; one beat per cycle under continuous beat_ready.
- Next request accepted the cycle after the last-beat handshake (one bubble between bursts).
- While beat_valid && !beat_ready all beat outputs hold stable.
- req_len=0: single beat, beat_last=1 on beat 0.
- aresetn low mid-burst: outputs take reset values asynchronously; burst discarded, nothing resumes.

## Configuration
- AXI4_BURST_CHECK_EN defined: beat_err=1 on every beat of a burst that is: WRAP with len∉{1,3,7,15} or unaligned addr; FIXED with len>15; INCR crossing a 4 KB boundary; B > DB. Illegal bursts still emit len+1 beats so back-end can answer SLVERR.
- Undefined: beat_err tied 0, no check logic.

## Structure
- Add to axi4_types: AXI4_BOUNDARY_BYTES=4096 constant, burst_len_t (logic [7:0]), function burst_bytes(burst_size_t).
- Sub-module axi4_burst_check: combinational legality checker, instantiated only under AXI4_BURST_CHECK_EN.

## Test plan
- INCR addr 0x1004 len 3 size 4B, DATA_WIDTH 64 -> addrs 0x1004,0x1008,0x100C,0x1010; strb 0xF0,0x0F,0xF0,0x0F; beat_last on idx 3.
- WRAP addr 0x38 len 3 size 8B -> 0x38,0x20,0x28,0x30; strb 0xFF each; last on 4th.
- FIXED addr 0x103 len 2 size 4B -> three beats addr 0x103, strb 0x08.
- INCR len 7 with beat_ready low 3 cycles at idx 2 -> addr/idx/strb stable, req_ready 0, sequence resumes unchanged.
- Check enabled: INCR 0xFF8 len 1 size 8B -> beat_err=1 both beats, addrs 0xFF8,0x1000; WRAP len 2 -> beat_err=1.
- aresetn low at idx 2 of len 7 -> beat_valid 0 immediately, req_ready 1; new request after release starts at idx 0.

Source files
------------

// File: rtl/axi4_types.sv
// Shared AXI4 burst encodings, generator state type and burst byte-count helper.
package axi4_types;

    typedef enum logic [2:0] {
        SIZE_1B   = 3'd0,
        SIZE_2B   = 3'd1,
        SIZE_4B   = 3'd2,
        SIZE_8B   = 3'd3,
        SIZE_16B  = 3'd4,
        SIZE_32B  = 3'd5,
        SIZE_64B  = 3'd6,
        SIZE_128B = 3'd7
    } burst_size_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_type_t;

    typedef logic [7:0] burst_len_t;

    typedef enum logic {
        GEN_IDLE  = 1'b0,
        GEN_BURST = 1'b1
    } gen_state_t;

    localparam int unsigned AXI4_BOUNDARY_BYTES = 4096;

    function automatic logic [7:0] burst_bytes(input burst_size_t size);
        return 8'd1 << size;
    endfunction

endpackage

// File: rtl/axi4_burst_check.sv
// Combinational AXI4 burst legality checker; only the low 12 address bits matter.
module axi4_burst_check
    import axi4_types::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [11:0]  i_addr_lo,
    input  burst_len_t   i_len,
    input  burst_size_t  i_size,
    input  burst_type_t  i_burst,
    output logic         o_err
);

    localparam int DB = DATA_WIDTH / 8;

    logic [7:0]  w_b;
    logic [16:0] w_total;
    logic [11:0] w_off;
    logic        w_cross;
    logic        w_unal;
    logic        w_wrap_len_ok;
    logic        w_too_big;

    assign w_b           = burst_bytes(i_size);
    assign w_total       = 17'(w_b) * (17'(i_len) + 17'd1);
    assign w_off         = i_addr_lo & ~12'(w_b - 8'd1);
    // The burst spans [aligned start, aligned start + total) within its 4 KB page
    assign w_cross       = (18'(w_off) + 18'(w_total)) > 18'(AXI4_BOUNDARY_BYTES);
    assign w_unal        = (i_addr_lo & 12'(w_b - 8'd1)) != 12'd0;
    assign w_wrap_len_ok = (i_len == 8'd1) || (i_len == 8'd3) || (i_len == 8'd7) || (i_len == 8'd15);
    assign w_too_big     = int'(w_b) > DB;

    always_comb begin
        o_err = w_too_big;
        case (i_burst)
            BURST_WRAP:  if (!w_wrap_len_ok || w_unal) o_err = 1'b1;
            BURST_FIXED: if (i_len > 8'd15)            o_err = 1'b1;
            BURST_INCR:  if (w_cross)                  o_err = 1'b1;
            default:     ;
        endcase
    end

endmodule

// File: rtl/axi4_burst_addr_gen.sv
// Expands one AXI4 burst descriptor into per-beat address/strobe/last.
// Define AXI4_BURST_CHECK_EN to flag illegal bursts on beat_err.
module axi4_burst_addr_gen
    import axi4_types::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  burst_len_t              req_len,
    input  burst_size_t             req_size,
    input  burst_type_t             req_burst,
    output logic                    beat_valid,
    input  logic                    beat_ready,
    output logic [ADDR_WIDTH-1:0]   beat_addr,
    output logic [DATA_WIDTH/8-1:0] beat_strb,
    output burst_len_t              beat_idx,
    output logic                    beat_last,
    output logic                    beat_err
);

    localparam int DB = DATA_WIDTH / 8;

    function automatic logic [DB-1:0] f_strb(input logic [ADDR_WIDTH-1:0] addr,
                                             input burst_size_t size);
        logic [DB-1:0]         m;
        logic [ADDR_WIDTH-1:0] b;
        logic [ADDR_WIDTH-1:0] lo;
        logic [ADDR_WIDTH-1:0] hi;
        b  = ADDR_WIDTH'(burst_bytes(size));
        lo = addr & ADDR_WIDTH'(DB - 1);
        hi = (addr & ~(b - ADDR_WIDTH'(1)) & ADDR_WIDTH'(DB - 1)) + b - ADDR_WIDTH'(1);
        for (int i = 0; i < DB; i++) begin
            m[i] = (ADDR_WIDTH'(i) >= lo) && (ADDR_WIDTH'(i) <= hi);
        end
        return m;
    endfunction

    gen_state_t            r_state;
    gen_state_t            w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_wrap_lo;
    logic [ADDR_WIDTH-1:0] r_wrap_hi;
    burst_len_t            r_len;
    burst_len_t            r_idx;
    burst_size_t           r_size;
    burst_type_t           r_burst;
    logic [DB-1:0]         r_strb;
    logic                  r_last;

    logic                  w_req_hs;
    logic                  w_beat_hs;
    logic [ADDR_WIDTH-1:0] w_req_b;
    logic [ADDR_WIDTH-1:0] w_req_wbytes;
    logic [ADDR_WIDTH-1:0] w_req_lower;
    logic [ADDR_WIDTH-1:0] w_b;
    logic [ADDR_WIDTH-1:0] w_inc_addr;
    logic [ADDR_WIDTH-1:0] w_next_addr;

    assign w_req_hs  = req_valid && req_ready;
    assign w_beat_hs = beat_valid && beat_ready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= GEN_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            GEN_IDLE:  if (req_valid)           w_state_nxt = GEN_BURST;
            GEN_BURST: if (beat_ready && r_last) w_state_nxt = GEN_IDLE;
            default:   w_state_nxt = GEN_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        beat_valid = 1'b0;
        case (r_state)
            GEN_IDLE:  req_ready  = 1'b1;
            GEN_BURST: beat_valid = 1'b1;
            default:   ;
        endcase
    end

    // Wrap window [lower, lower+W) is fixed for the whole burst, so capture it once
    assign w_req_b      = ADDR_WIDTH'(burst_bytes(req_size));
    assign w_req_wbytes = w_req_b * (ADDR_WIDTH'(req_len) + ADDR_WIDTH'(1));
    assign w_req_lower  = req_addr & ~(w_req_wbytes - ADDR_WIDTH'(1));

    assign w_b        = ADDR_WIDTH'(burst_bytes(r_size));
    assign w_inc_addr = (r_addr & ~(w_b - ADDR_WIDTH'(1))) + w_b;

    always_comb begin
        w_next_addr = w_inc_addr;
        case (r_burst)
            BURST_FIXED: w_next_addr = r_addr;
            BURST_WRAP:  if (w_inc_addr == r_wrap_hi) w_next_addr = r_wrap_lo;
            default:     ;
        endcase
    end

    // Beat registers freeze on the last beat so IDLE shows the final beat's values
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_addr    <= '0;
            r_wrap_lo <= '0;
            r_wrap_hi <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_size    <= SIZE_1B;
            r_burst   <= BURST_FIXED;
            r_strb    <= '0;
            r_last    <= 1'b0;
        end else if (w_req_hs) begin
            r_addr    <= req_addr;
            r_wrap_lo <= w_req_lower;
            r_wrap_hi <= w_req_lower + w_req_wbytes;
            r_len     <= req_len;
            r_idx     <= '0;
            r_size    <= req_size;
            r_burst   <= req_burst;
            r_strb    <= f_strb(req_addr, req_size);
            r_last    <= (req_len == 8'd0);
        end else if (w_beat_hs && !r_last) begin
            r_addr    <= w_next_addr;
            r_idx     <= r_idx + 8'd1;
            r_strb    <= f_strb(w_next_addr, r_size);
            r_last    <= ((r_idx + 8'd1) == r_len);
        end
    end

    assign beat_addr = r_addr;
    assign beat_strb = r_strb;
    assign beat_idx  = r_idx;
    assign beat_last = r_last;

`ifdef AXI4_BURST_CHECK_EN
    logic w_chk_err;
    logic r_err;

    axi4_burst_check #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_check (
        .i_addr_lo (req_addr[11:0]),
        .i_len     (req_len),
        .i_size    (req_size),
        .i_burst   (req_burst),
        .o_err     (w_chk_err)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)      r_err <= 1'b0;
        else if (w_req_hs) r_err <= w_chk_err;
    end

    assign beat_err = r_err;
`else
    assign beat_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_burst_addr_gen.sv
// Randomized self-checking bench for axi4_burst_addr_gen against a closed-form burst model.
module tb_axi4_burst_addr_gen;
    import axi4_types::*;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int DB = DW / 8;

    logic           aclk = 1'b0;
    logic           aresetn;
    logic           req_valid;
    logic           req_ready;
    logic [AW-1:0]  req_addr;
    burst_len_t     req_len;
    burst_size_t    req_size;
    burst_type_t    req_burst;
    logic           beat_valid;
    logic           beat_ready;
    logic [AW-1:0]  beat_addr;
    logic [DB-1:0]  beat_strb;
    burst_len_t     beat_idx;
    logic           beat_last;
    logic           beat_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 aclk = ~aclk;

    axi4_burst_addr_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_size   (req_size),
        .req_burst  (req_burst),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .beat_addr  (beat_addr),
        .beat_strb  (beat_strb),
        .beat_idx   (beat_idx),
        .beat_last  (beat_last),
        .beat_err   (beat_err)
    );

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Address of beat n: closed form for power-of-two wrap windows, stepwise otherwise
    function automatic logic [31:0] m_addr(input logic [31:0] a, input int len, input int size,
                                           input burst_type_t bt, input int n);
        logic [31:0] b, al, w, lo, cur;
        b  = 32'd1 << size;
        al = a & ~(b - 32'd1);
        if (n == 0 || bt == BURST_FIXED) return a;
        if (bt == BURST_WRAP) begin
            w  = b * 32'(len + 1);
            lo = a & ~(w - 32'd1);
            if (((len + 1) & len) == 0) return lo + (((al - lo) + 32'(n) * b) % w);
            cur = a;
            for (int k = 0; k < n; k++) begin
                cur = (cur & ~(b - 32'd1)) + b;
                if (cur == lo + w) cur = lo;
            end
            return cur;
        end
        return al + 32'(n) * b;
    endfunction

    function automatic logic [DB-1:0] m_strb(input logic [31:0] a, input int size);
        logic [DB-1:0] m;
        int b, lo, hi;
        b  = 1 << size;
        lo = int'(a % DB);
        hi = int'((a & ~(32'(b) - 32'd1)) % DB) + b - 1;
        for (int i = 0; i < DB; i++) m[i] = (i >= lo) && (i <= hi);
        return m;
    endfunction

    function automatic logic m_err(input logic [31:0] a, input int len, input int size,
                                   input burst_type_t bt);
`ifdef AXI4_BURST_CHECK_EN
        longint b, al, total;
        logic e;
        b     = longint'(1) << size;
        al    = longint'(a) & ~(b - 1);
        total = b * (len + 1);
        e     = (b > DB);
        if (bt == BURST_WRAP && (!(len inside {1, 3, 7, 15}) || (longint'(a) % b) != 0)) e = 1'b1;
        if (bt == BURST_FIXED && len > 15) e = 1'b1;
        if (bt == BURST_INCR && (al / 4096) != ((al + total - 1) / 4096)) e = 1'b1;
        return e;
`else
        return 1'b0;
`endif
    endfunction

    task automatic run_burst(input logic [31:0] a, input int len, input int size,
                             input burst_type_t bt, input int stall_at, input int stall_n,
                             input bit rnd_stall);
        int budget;
        int st;
        logic        e_err;
        logic [31:0] e_addr;
        e_err      = m_err(a, len, size, bt);
        req_addr   = a;
        req_len    = 8'(len);
        req_size   = burst_size_t'(size);
        req_burst  = bt;
        req_valid  = 1'b1;
        beat_ready = 1'b0;
        budget = 0;
        while (!req_ready && budget < 20) begin
            @(posedge aclk); #1;
            budget++;
        end
        chk_eq("req_ready_idle", 64'(req_ready), 64'd1);
        @(posedge aclk); #1;
        req_valid = 1'b0;
        for (int n = 0; n <= len; n++) begin
            e_addr = m_addr(a, len, size, bt, n);
            if (n == stall_at)   st = stall_n;
            else if (rnd_stall)  st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            else                 st = 0;
            for (int s = 0; s <= st; s++) begin
                beat_ready = (s == st);
                @(negedge aclk);
                chk_eq("beat_valid", 64'(beat_valid), 64'd1);
                chk_eq("req_ready_busy", 64'(req_ready), 64'd0);
                chk_eq("beat_addr", 64'(beat_addr), 64'(e_addr));
                chk_eq("beat_strb", 64'(beat_strb), 64'(m_strb(e_addr, size)));
                chk_eq("beat_idx", 64'(beat_idx), 64'(n));
                chk_eq("beat_last", 64'(beat_last), 64'(n == len));
                chk_eq("beat_err", 64'(beat_err), 64'(e_err));
                @(posedge aclk); #1;
            end
        end
        beat_ready = 1'b0;
        chk_eq("bubble_valid", 64'(beat_valid), 64'd0);
        chk_eq("bubble_ready", 64'(req_ready), 64'd1);
    endtask

    task automatic check_reset_vals(input string pfx);
        chk_eq({pfx, "_req_ready"}, 64'(req_ready), 64'd1);
        chk_eq({pfx, "_beat_valid"}, 64'(beat_valid), 64'd0);
        chk_eq({pfx, "_beat_addr"}, 64'(beat_addr), 64'd0);
        chk_eq({pfx, "_beat_strb"}, 64'(beat_strb), 64'd0);
        chk_eq({pfx, "_beat_idx"}, 64'(beat_idx), 64'd0);
        chk_eq({pfx, "_beat_last"}, 64'(beat_last), 64'd0);
        chk_eq({pfx, "_beat_err"}, 64'(beat_err), 64'd0);
    endtask

    task automatic reset_mid_burst();
        req_addr   = 32'h0000_2000;
        req_len    = 8'd7;
        req_size   = SIZE_4B;
        req_burst  = BURST_INCR;
        req_valid  = 1'b1;
        beat_ready = 1'b1;
        @(posedge aclk); #1;
        req_valid = 1'b0;
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        beat_ready = 1'b0;
        @(negedge aclk);
        chk_eq("mid_idx_before_rst", 64'(beat_idx), 64'd2);
        #2 aresetn = 1'b0;
        #1 check_reset_vals("mid_rst");
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        chk_eq("post_rst_valid", 64'(beat_valid), 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        int size, len, sel;
        burst_type_t bt;
        int wrap_lens[4] = '{1, 3, 7, 15};

        aresetn    = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_len    = '0;
        req_size   = SIZE_1B;
        req_burst  = BURST_FIXED;
        beat_ready = 1'b0;
        #12;
        check_reset_vals("reset");
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;

        run_burst(32'h0000_1004, 3, 2, BURST_INCR,  -1, 0, 1'b0);
        run_burst(32'h0000_0038, 3, 3, BURST_WRAP,  -1, 0, 1'b0);
        run_burst(32'h0000_0103, 2, 2, BURST_FIXED, -1, 0, 1'b0);
        run_burst(32'h0000_0400, 7, 2, BURST_INCR,   2, 3, 1'b0);
        run_burst(32'h0000_0FF8, 1, 3, BURST_INCR,  -1, 0, 1'b0);
        run_burst(32'h0000_0040, 2, 3, BURST_WRAP,  -1, 0, 1'b0);
        run_burst(32'h0000_0010, 0, 3, BURST_INCR,  -1, 0, 1'b0);
        run_burst(32'hFFFF_FFF8, 2, 3, BURST_INCR,  -1, 0, 1'b0);
        run_burst(32'h0000_0011, 3, 5, BURST_INCR,  -1, 0, 1'b0);

        reset_mid_burst();
        run_burst(32'h0000_3000, 3, 2, BURST_INCR, -1, 0, 1'b0);

        for (int t = 0; t < 80; t++) begin
            sel = int'($urandom_range(0, 3));
            if (sel == 0)      a = ($urandom & 32'hFFFF_F000) | (32'hFF0 + 32'($urandom_range(0, 15)));
            else if (sel == 1) a = 32'hFFFF_FFC0 + 32'($urandom_range(0, 63));
            else               a = $urandom;
            size = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 5)) : int'($urandom_range(0, 3));
            bt   = burst_type_t'($urandom_range(0, 2));
            if (bt == BURST_WRAP) begin
                len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15))
                                                  : wrap_lens[$urandom_range(0, 3)];
                if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << size) - 32'd1);
            end else begin
                len = int'($urandom_range(0, 20));
            end
            run_burst(a, len, size, bt, -1, 0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
